// File: rtl/code_sequencer.sv
// Purpose: steps a 4-bit code through a loadable table, on a prescaled tick or a debounced button press.
// Latency: index/tick/wrap update one edge after the advance decision; SW is a combinational read of the table at index.
// Backpressure: none; the downstream decoder is combinational and always accepts SW.
module code_sequencer #(
    parameter int TICK_DIV        = 50000000,
    parameter int SEQ_LEN         = 8,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic       dir,
    input  logic       step_btn,
    input  logic       load_en,
    input  logic [3:0] load_addr,
    input  logic [3:0] load_data,
    output logic [3:0] SW,
    output logic [3:0] index,
    output logic       tick,
    output logic       wrap
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [DW-1:0] DB_MAX    = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [3:0]    IDX_LAST  = 4'(SEQ_LEN - 1);
    localparam logic [4:0]    LEN_EXT   = 5'(SEQ_LEN);

    typedef enum logic {
        PAUSED  = 1'b0,
        RUNNING = 1'b1
    } state_t;

    state_t          state;
    state_t          next_state;
    logic [PW-1:0]   presc;
    logic            sync1;
    logic            sync2;
    logic            deb;
    logic [DW-1:0]   db_cnt;
    logic            step_req;
    logic            auto_adv;
    logic            step_adv;
    logic            presc_en;
    logic            advance;
    logic [3:0]      code_tbl [16];

    // Mode register: paused or auto-running.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= PAUSED;
        end else begin
            state <= next_state;
        end
    end

    // Mode transitions follow the run level directly.
    always_comb begin
        next_state = state;
        case (state)
            PAUSED:  if (run)  next_state = RUNNING;
            RUNNING: if (!run) next_state = PAUSED;
            default: next_state = PAUSED;
        endcase
    end

    // Advance sources: prescaler terminal count while running, button press while paused.
    always_comb begin
        presc_en = 1'b0;
        auto_adv = 1'b0;
        step_adv = 1'b0;
        case (state)
            RUNNING: begin
                presc_en = run;
                auto_adv = run && (presc == PRESC_MAX);
            end
            PAUSED: begin
                step_adv = step_req;
            end
            default: begin
                presc_en = 1'b0;
            end
        endcase
    end

    assign advance = auto_adv | step_adv;

    // Prescaler: counts while running, held at zero otherwise so re-entry gets a full period.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc <= '0;
        end else if (!presc_en) begin
            presc <= '0;
        end else if (presc == PRESC_MAX) begin
            presc <= '0;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    // Button synchroniser and debounce: accept a new level only after it has been stable long enough.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            deb    <= 1'b0;
            db_cnt <= '0;
        end else begin
            sync1 <= step_btn;
            sync2 <= sync1;
            if (sync2 == deb) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_MAX) begin
                deb    <= sync2;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

    // A press is the edge on which the debounced level flips from 0 to 1.
    assign step_req = sync2 && !deb && (db_cnt == DB_MAX);

    // Index update with wrap detection; tick and wrap are single-cycle registered pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            index <= '0;
            tick  <= 1'b0;
            wrap  <= 1'b0;
        end else begin
            tick <= advance;
            wrap <= 1'b0;
            if (advance) begin
                if (!dir) begin
                    if (index >= IDX_LAST) begin
                        index <= '0;
                        wrap  <= 1'b1;
                    end else begin
                        index <= index + 1'b1;
                    end
                end else begin
                    if (index == '0) begin
                        index <= IDX_LAST;
                        wrap  <= 1'b1;
                    end else begin
                        index <= index - 1'b1;
                    end
                end
            end
        end
    end

    // Code table: identity on reset, writes beyond the active length are dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                code_tbl[i] <= 4'(i);
            end
        end else if (load_en && ({1'b0, load_addr} < LEN_EXT)) begin
            code_tbl[load_addr] <= load_data;
        end
    end

    assign SW = code_tbl[index];

endmodule
